gan_generator_v2: RTL and testbench



---
 rtl/gan_generator_v2.sv | 215 +++++++++++++++++++++
 tb/tb_gan_generator_v2.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gan_generator_v2.sv
// Frame-based encoder/decoder image generator: loads a 32x32 Q8.8 frame, runs five fixed
// stencil layers one pixel per cycle through two ping-pong buffers, and streams hard-tanh output.
module gan_generator_v2 #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [2:0] {
    StLoad,
    StEnc1,
    StEnc2,
    StEnc3,
    StDec1,
    StDec2
  } state_e;

  state_e state_q, state_d, state_nxt;
  logic [9:0] pix_q, pix_d;

  // Buffer A holds the input frame, then Enc2 and Dec1 results; B holds Enc1 and Enc3 results.
  logic signed [15:0] buf_a_q [1024];
  logic signed [15:0] buf_b_q [1024];

  logic               val_act1, val_act2, val_act3, val_act_d1, val_act_d2;
  logic signed [15:0] dat_act1, dat_act2, dat_act3, dat_act_d1, dat_act_d2;

  logic               valid_out_q;
  logic signed [15:0] data_out_q;

  logic [9:0]         last_pix;
  logic [2:0]         out_lg, in_lg;
  logic               use_b;
  int                 orow, ocol, id, i0, j0;

  logic signed [23:0] acc, shifted;
  logic [2:0]         shamt;
  logic signed [15:0] sat_v, act, clamp_v;

  // Zero-padded tap read from the current source buffer (row stride d).
  function automatic logic signed [23:0] rd(input logic from_b, input int r, input int c,
                                            input int d);
    logic [9:0] idx;
    rd = '0;
    if (r >= 0 && r < d && c >= 0 && c < d) begin
      idx = 10'(r * d + c);
      rd  = 24'(from_b ? buf_b_q[idx] : buf_a_q[idx]);
    end
  endfunction

  // Per-layer geometry: output/input dimension (log2), source buffer and successor state.
  always_comb begin
    last_pix  = 10'd1023;
    out_lg    = 3'd5;
    in_lg     = 3'd5;
    use_b     = 1'b0;
    state_nxt = StLoad;
    unique case (state_q)
      StLoad: state_nxt = StEnc1;
      StEnc1: state_nxt = StEnc2;
      StEnc2: begin
        last_pix  = 10'd255;
        out_lg    = 3'd4;
        use_b     = 1'b1;
        state_nxt = StEnc3;
      end
      StEnc3: begin
        last_pix  = 10'd63;
        out_lg    = 3'd3;
        in_lg     = 3'd4;
        state_nxt = StDec1;
      end
      StDec1: begin
        last_pix  = 10'd255;
        out_lg    = 3'd4;
        in_lg     = 3'd3;
        use_b     = 1'b1;
        state_nxt = StDec2;
      end
      StDec2: begin
        in_lg     = 3'd4;
        state_nxt = StLoad;
      end
      default: ;
    endcase
    orow = int'(pix_q) >> out_lg;
    ocol = int'(pix_q) & ((1 << out_lg) - 1);
    id   = 1 << in_lg;
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    if (state_q != StLoad || valid_in) begin
      if (pix_q == last_pix) begin
        pix_d   = '0;
        state_d = state_nxt;
      end else begin
        pix_d = pix_q + 10'd1;
      end
    end
  end

  // One output pixel per cycle from the current layer's stencil.
  always_comb begin
    acc   = '0;
    shamt = 3'd0;
    i0    = 0;
    j0    = 0;
    unique case (state_q)
      StEnc1: begin
        acc = (rd(use_b, orow, ocol, id) <<< 2)
            + rd(use_b, orow - 1, ocol, id) + rd(use_b, orow + 1, ocol, id)
            + rd(use_b, orow, ocol - 1, id) + rd(use_b, orow, ocol + 1, id);
        shamt = 3'd3;
      end
      StEnc2, StEnc3: begin
        for (int a = 0; a < 4; a++) begin
          for (int b = 0; b < 4; b++) begin
            acc = acc + rd(use_b, 2 * orow - 1 + a, 2 * ocol - 1 + b, id);
          end
        end
        shamt = 3'd4;
      end
      StDec1, StDec2: begin
        i0 = (orow + 1) >> 1;
        j0 = (ocol + 1) >> 1;
        for (int a = 0; a < 2; a++) begin
          for (int b = 0; b < 2; b++) begin
            acc = acc + rd(use_b, i0 - 1 + a, j0 - 1 + b, id);
          end
        end
        shamt = 3'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = acc >>> shamt;
    if (shifted > 24'sd32767) begin
      sat_v = 16'sh7fff;
    end else if (shifted < -24'sd32768) begin
      sat_v = 16'sh8000;
    end else begin
      sat_v = shifted[15:0];
    end
    act = sat_v[15] ? (sat_v >>> 3) : sat_v;

    if (dat_act_d2 > 16'sd256) begin
      clamp_v = 16'sd256;
    end else if (dat_act_d2 < -16'sd256) begin
      clamp_v = -16'sd256;
    end else begin
      clamp_v = dat_act_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      pix_q       <= '0;
      val_act1    <= 1'b0;
      val_act2    <= 1'b0;
      val_act3    <= 1'b0;
      val_act_d1  <= 1'b0;
      val_act_d2  <= 1'b0;
      dat_act1    <= '0;
      dat_act2    <= '0;
      dat_act3    <= '0;
      dat_act_d1  <= '0;
      dat_act_d2  <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      val_act1    <= (state_q == StEnc1);
      val_act2    <= (state_q == StEnc2);
      val_act3    <= (state_q == StEnc3);
      val_act_d1  <= (state_q == StDec1);
      val_act_d2  <= (state_q == StDec2);
      if (state_q == StEnc1) dat_act1 <= act;
      if (state_q == StEnc2) dat_act2 <= act;
      if (state_q == StEnc3) dat_act3 <= act;
      if (state_q == StDec1) dat_act_d1 <= act;
      if (state_q == StDec2) dat_act_d2 <= act;
      valid_out_q <= val_act_d2;
      if (val_act_d2) data_out_q <= clamp_v;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StLoad && valid_in) begin
      buf_a_q[pix_q] <= data_in;
    end else if (state_q == StEnc2 || state_q == StDec1) begin
      buf_a_q[pix_q] <= act;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StEnc1 || state_q == StEnc3) begin
      buf_b_q[pix_q] <= act;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_gan_generator_v2.sv
// Scoreboard bench for gan_generator_v2: a plain-arithmetic layer model pushes expected pixels,
// independent monitors pop and compare data_out and the Enc1 probe.
module tb_gan_generator_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] data_in;
  logic        valid_out;
  logic [15:0] data_out;

  gan_generator_v2 #(.DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_out[$];
  int exp_a1[$];
  int emark_q[$];
  int ncyc = 0;
  bit chk_a1 = 1'b1;
  int stray = 0;
  int a1_idx = 0;
  int act1_cap[1024];
  int cnt2 = 0, cnt3 = 0, cntd1 = 0, cntd2 = 0, cnt_out = 0;
  int out_min = 0, out_max = 0;
  logic prev_vo = 1'b0;

  int frame[1024];
  int saved[1024];
  int src[32][32];
  int dst[32][32];
  int n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int px(input int r, input int c);
    if (r < 0 || c < 0 || r >= n || c >= n) return 0;
    return src[r][c];
  endfunction

  function automatic int lrelu_sat(input int x);
    int s;
    s = (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
    return (s >= 0) ? s : (s >>> 3);
  endfunction

  task automatic copy_back(input int dim);
    for (int r = 0; r < dim; r++) for (int c = 0; c < dim; c++) src[r][c] = dst[r][c];
    n = dim;
  endtask

  task automatic enc_layer();
    int s;
    for (int i = 0; i < n / 2; i++) begin
      for (int j = 0; j < n / 2; j++) begin
        s = 0;
        for (int r = 2 * i - 1; r <= 2 * i + 2; r++)
          for (int c = 2 * j - 1; c <= 2 * j + 2; c++) s += px(r, c);
        dst[i][j] = lrelu_sat(s >>> 4);
      end
    end
    copy_back(n / 2);
  endtask

  task automatic dec_layer();
    int s, ii, jj;
    for (int y = 0; y < 2 * n; y++) begin
      for (int x = 0; x < 2 * n; x++) begin
        ii = (y + 1) / 2;
        jj = (x + 1) / 2;
        s = px(ii - 1, jj - 1) + px(ii - 1, jj) + px(ii, jj - 1) + px(ii, jj);
        dst[y][x] = lrelu_sat(s >>> 2);
      end
    end
    copy_back(2 * n);
  endtask

  task automatic run_model();
    int s, v;
    n = 32;
    for (int i = 0; i < 1024; i++) src[i / 32][i % 32] = frame[i];
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        s = 4 * px(r, c) + px(r - 1, c) + px(r + 1, c) + px(r, c - 1) + px(r, c + 1);
        dst[r][c] = lrelu_sat(s >>> 3);
        exp_a1.push_back(dst[r][c]);
      end
    end
    copy_back(32);
    enc_layer();
    enc_layer();
    dec_layer();
    dec_layer();
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        v = src[r][c];
        exp_out.push_back((v > 256) ? 256 : (v < -256) ? -256 : v);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (valid_out) begin
      cnt_out++;
      if (exp_out.size() == 0) begin
        stray++;
        check("stray_valid_out", 1, 0);
      end else begin
        if (!prev_vo && emark_q.size() > 0)
          check("first_out_latency", ncyc - emark_q.pop_front(), 1602);
        if ($signed(data_out) < out_min) out_min = $signed(data_out);
        if ($signed(data_out) > out_max) out_max = $signed(data_out);
        check("data_out", $signed(data_out), exp_out.pop_front());
      end
    end
    if (dut.val_act1 && chk_a1) begin
      if (exp_a1.size() == 0) begin
        check("stray_val_act1", 1, 0);
      end else begin
        if (a1_idx < 1024) act1_cap[a1_idx] = $signed(dut.dat_act1);
        a1_idx++;
        check("dat_act1", $signed(dut.dat_act1), exp_a1.pop_front());
      end
    end
    cnt2  += int'(dut.val_act2);
    cnt3  += int'(dut.val_act3);
    cntd1 += int'(dut.val_act_d1);
    cntd2 += int'(dut.val_act_d2);
    prev_vo = valid_out;
    ncyc++;
  end

  // ---------------- stimulus ----------------
  task automatic clear_counts();
    cnt2 = 0; cnt3 = 0; cntd1 = 0; cntd2 = 0; cnt_out = 0; a1_idx = 0;
    out_min = 0; out_max = 0;
  endtask

  task automatic drive(input int npix, input bit flush, input bit mark);
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      #1;
      valid_in = 1'b1;
      data_in  = 16'(frame[i]);
      if (i == 1023 && mark) emark_q.push_back(ncyc);
    end
    @(negedge clk);
    #1;
    if (flush) begin
      repeat (2000) begin
        valid_in = 1'b1;
        data_in  = 16'($urandom);
        @(negedge clk);
        #1;
      end
    end
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit flush);
    int t;
    clear_counts();
    run_model();
    drive(1024, flush, 1'b1);
    t = 0;
    while ((exp_out.size() != 0 || valid_out) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain_left"}, exp_out.size(), 0);
    check({tag, "_cnt_act2"}, cnt2, 256);
    check({tag, "_cnt_act3"}, cnt3, 64);
    check({tag, "_cnt_act_d1"}, cntd1, 256);
    check({tag, "_cnt_act_d2"}, cntd2, 1024);
    check({tag, "_cnt_out"}, cnt_out, 1024);
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < 1024; i++) frame[i] = v;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 3) == 0) frame[i] = $signed(16'($urandom));
      else frame[i] = int'($urandom_range(0, 1024)) - 512;
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_val_act1", int'(dut.val_act1), 0);
    check("rst_val_act_d2", int'(dut.val_act_d2), 0);
    check("rst_dat_act3", int'(dut.dat_act3), 0);
    #1;
    rst = 1'b0;

    set_const(0);
    run_frame("zero", 1'b0);

    set_const(256);
    run_frame("c256", 1'b0);
    check("c256_corner", act1_cap[0], 192);
    check("c256_edge", act1_cap[1], 224);
    check("c256_interior", act1_cap[33], 256);

    set_const(-256);
    run_frame("cneg", 1'b0);
    check("cneg_interior", act1_cap[33], -32);
    check("cneg_out_max_le0", int'(out_max <= 0), 1);
    check("cneg_out_min_ge-256", int'(out_min >= -256), 1);

    set_const(0);
    frame[10 * 32 + 10] = 2048;
    run_frame("imp", 1'b0);
    check("imp_center", act1_cap[330], 1024);
    check("imp_up", act1_cap[298], 256);
    check("imp_right", act1_cap[331], 256);
    check("imp_far", act1_cap[0], 0);
    check("imp_out_in_range", int'(out_max <= 256 && out_min >= -256), 1);

    set_rand();
    for (int i = 0; i < 1024; i++) saved[i] = frame[i];
    run_frame("flush", 1'b1);
    for (int i = 0; i < 1024; i++) frame[i] = saved[i];
    run_frame("noflush", 1'b0);

    set_rand();
    drive(500, 1'b0, 1'b0);
    pulse_reset();
    set_rand();
    run_frame("rst_load", 1'b0);

    set_rand();
    chk_a1 = 1'b0;
    drive(1024, 1'b0, 1'b0);
    repeat (1000) @(negedge clk);
    pulse_reset();
    chk_a1 = 1'b1;
    clear_counts();
    repeat (3000) @(negedge clk);
    check("abort_no_output", cnt_out, 0);
    check("abort_no_act_d2", cntd2, 0);
    set_rand();
    run_frame("post_abort", 1'b0);

    check("a1_queue_empty", exp_a1.size(), 0);
    check("stray_total", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
